// File: rtl/square_fold_rr_scheduler.sv
// Round-robin front end that shares one pipelined square-and-fold datapath among NUM_REQ requesters.
// Each result is tagged with the requester ID and returns to that requester 3+EXTRA_STAGES edges after acceptance.
module square_fold_rr_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int BITWIDTH     = 16,
  parameter int EXTRA_STAGES = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [BITWIDTH-1:0]          rsp_data,
  output logic [2:0]                   in_flight,
  output logic                         idle
);

  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW        = 2 * BITWIDTH;
  localparam int OUT_DEPTH = EXTRA_STAGES + 1;

  logic [IDW-1:0]      ptr;
  logic                grant_any;
  logic [IDW-1:0]      grant_id;
  logic [IDW-1:0]      search_idx;

  logic                s1_valid;
  logic [IDW-1:0]      s1_id;
  logic [BITWIDTH-1:0] s1_op;
  logic                s2_valid;
  logic [IDW-1:0]      s2_id;
  logic [PW-1:0]       s2_prod;

  logic [OUT_DEPTH-1:0] out_valid;
  logic [IDW-1:0]       out_id   [OUT_DEPTH];
  logic [BITWIDTH-1:0]  out_data [OUT_DEPTH];
  logic                 rsp_fire;

  // Search starts one past the last winner, so the most recent grantee has lowest priority.
  always_comb begin
    grant_any  = 1'b0;
    grant_id   = '0;
    search_idx = '0;
    req_ready  = '0;
    if (!hold) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        search_idx = IDW'((int'(ptr) + k) % NUM_REQ);
        if (!grant_any && req_valid[search_idx]) begin
          grant_any = 1'b1;
          grant_id  = search_idx;
        end
      end
    end
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= IDW'(NUM_REQ - 1);
    end else if (grant_any) begin
      ptr <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= '0;
    end else begin
      s1_valid     <= grant_any;
      s2_valid     <= s1_valid;
      out_valid[0] <= s2_valid;
      for (int i = 1; i < OUT_DEPTH; i++) begin
        out_valid[i] <= out_valid[i-1];
      end
    end
  end

  // Data and tags travel beside the valid bits; they are meaningless unless qualified, so no reset.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      s1_op <= req_data[grant_id*BITWIDTH +: BITWIDTH];
      s1_id <= grant_id;
    end
    s2_prod     <= PW'(s1_op) * PW'(s1_op);
    s2_id       <= s1_id;
    out_data[0] <= s2_prod[BITWIDTH-1:0] ^ s2_prod[PW-1:BITWIDTH];
    out_id[0]   <= s2_id;
    for (int i = 1; i < OUT_DEPTH; i++) begin
      out_data[i] <= out_data[i-1];
      out_id[i]   <= out_id[i-1];
    end
  end

  assign rsp_fire = out_valid[OUT_DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= 3'd0;
    end else begin
      case ({grant_any, rsp_fire})
        2'b10:   in_flight <= in_flight + 3'd1;
        2'b01:   in_flight <= in_flight - 3'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Response bus is forced to zero when nothing returns, so reset clears it immediately.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rsp_fire) begin
      rsp_valid[out_id[OUT_DEPTH-1]] = 1'b1;
      rsp_data                       = out_data[OUT_DEPTH-1];
    end
  end

  assign idle = (in_flight == 3'd0) && (req_valid == '0);

  a_in_flight_bound: assert property (@(posedge clk) disable iff (!reset)
    in_flight <= 3'(3 + EXTRA_STAGES));

endmodule

// File: tb/tb_square_fold_rr_scheduler.sv
// Directed, table-driven bench for square_fold_rr_scheduler (dut_a: EXTRA_STAGES=0, dut_b: EXTRA_STAGES=2).
module tb_square_fold_rr_scheduler;

  logic        clk;
  logic        reset;
  logic        a_hold, b_hold;
  logic [3:0]  a_valid, b_valid;
  logic [63:0] a_data, b_data;
  logic [3:0]  a_ready, b_ready;
  logic [3:0]  a_rsp_valid, b_rsp_valid;
  logic [15:0] a_rsp_data, b_rsp_data;
  logic [2:0]  a_in_flight, b_in_flight;
  logic        a_idle, b_idle;

  int checks;
  int failures;

  square_fold_rr_scheduler #(.NUM_REQ(4), .BITWIDTH(16), .EXTRA_STAGES(0)) dut_a (
    .clk(clk), .reset(reset), .hold(a_hold), .req_valid(a_valid), .req_data(a_data),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .in_flight(a_in_flight), .idle(a_idle)
  );

  square_fold_rr_scheduler #(.NUM_REQ(4), .BITWIDTH(16), .EXTRA_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .hold(b_hold), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .in_flight(b_in_flight), .idle(b_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        rst_n;
    logic        hold;
    logic [3:0]  valid;
    logic [63:0] data;
    logic [3:0]  ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic [2:0]  in_flight;
    logic        idle;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(logic [15:0] d0, logic [15:0] d1, logic [15:0] d2, logic [15:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(string name, logic rst_n, logic hold, logic [3:0] valid, logic [63:0] data,
                              logic [3:0] ready, logic [3:0] rv, logic [15:0] rd, logic [2:0] fl, logic idle);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.hold = hold; v.valid = valid; v.data = data;
    v.ready = ready; v.rsp_valid = rv; v.rsp_data = rd; v.in_flight = fl; v.idle = idle;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input bit use_b);
    reset = v.rst_n;
    if (use_b) begin
      b_hold = v.hold; b_valid = v.valid; b_data = v.data;
    end else begin
      a_hold = v.hold; a_valid = v.valid; a_data = v.data;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drives one vector at the falling edge, checks just after, then steps to the next falling edge.
  task automatic run_vec(input vec_t v, input bit use_b);
    applyStimulus(v, use_b);
    #1;
    checkOutput({v.name, ".ready"},     use_b ? 64'(b_ready)     : 64'(a_ready),     64'(v.ready));
    checkOutput({v.name, ".rsp_valid"}, use_b ? 64'(b_rsp_valid) : 64'(a_rsp_valid), 64'(v.rsp_valid));
    checkOutput({v.name, ".rsp_data"},  use_b ? 64'(b_rsp_data)  : 64'(a_rsp_data),  64'(v.rsp_data));
    checkOutput({v.name, ".in_flight"}, use_b ? 64'(b_in_flight) : 64'(a_in_flight), 64'(v.in_flight));
    checkOutput({v.name, ".idle"},      use_b ? 64'(b_idle)      : 64'(a_idle),      64'(v.idle));
    @(negedge clk);
  endtask

  logic [15:0] sd [4];
  logic [15:0] sr [4];

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    a_hold = 1'b0; a_valid = '0; a_data = '0;
    b_hold = 1'b0; b_valid = '0; b_data = '0;
    sd = '{16'h0010, 16'h0101, 16'h8000, 16'h0003};
    sr = '{16'h0100, 16'h0200, 16'h4000, 16'h0009};
    #2 reset = 1'b0;
    @(negedge clk);

    vecs.push_back(mk("rst",   0, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd0, 1));
    vecs.push_back(mk("s1.c0", 1, 0, 4'b0001, pk(16'h0003, 0, 0, 0), 4'b0001, 4'b0000, 16'h0000, 3'd0, 0));
    vecs.push_back(mk("s1.c1", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd1, 0));
    vecs.push_back(mk("s1.c2", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd1, 0));
    vecs.push_back(mk("s1.c3", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0001, 16'h0009, 3'd1, 0));
    vecs.push_back(mk("s1.c4", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd0, 1));
    vecs.push_back(mk("s2.c0", 1, 0, 4'b0100, pk(0, 0, 16'hFFFF, 0), 4'b0100, 4'b0000, 16'h0000, 3'd0, 0));
    vecs.push_back(mk("s2.c1", 1, 0, 4'b0100, pk(0, 0, 16'h0100, 0), 4'b0100, 4'b0000, 16'h0000, 3'd1, 0));
    vecs.push_back(mk("s2.c2", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd2, 0));
    vecs.push_back(mk("s2.c3", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0100, 16'hFFFF, 3'd2, 0));
    vecs.push_back(mk("s2.c4", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0100, 16'h0001, 3'd1, 0));
    vecs.push_back(mk("s2.c5", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd0, 1));
    vecs.push_back(mk("rst2",  0, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd0, 1));
    for (int k = 0; k < 12; k++) begin
      logic [3:0] vv, rr, rv;
      logic [15:0] rd;
      logic [2:0] fl;
      vv = (k < 8) ? 4'hF : 4'h0;
      rr = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
      rv = (k >= 3 && k <= 10) ? 4'(1 << ((k + 1) % 4)) : 4'h0;
      rd = (k >= 3 && k <= 10) ? sr[(k + 1) % 4] : 16'h0;
      fl = (k <= 3) ? 3'(k) : ((k <= 8) ? 3'd3 : 3'(11 - k));
      vecs.push_back(mk($sformatf("s3.c%0d", k), 1, 0, vv, pk(sd[0], sd[1], sd[2], sd[3]), rr, rv, rd, fl, k == 11));
    end

    foreach (vecs[i]) run_vec(vecs[i], 0);

    // Wrap-around: park ptr on 1, then 3 wins over 1, then newly raised 0 wins over 1.
    run_vec(mk("wr.p", 1, 0, 4'b0010, pk(0, 16'h0002, 0, 0), 4'b0010, 4'b0000, 16'h0000, 3'd0, 0), 0);
    run_vec(mk("wr.a", 1, 0, 4'b1010, pk(0, 16'h0002, 0, 16'h0005), 4'b1000, 4'b0000, 16'h0000, 3'd1, 0), 0);
    run_vec(mk("wr.b", 1, 0, 4'b0011, pk(16'h0007, 16'h0002, 0, 0), 4'b0001, 4'b0000, 16'h0000, 3'd2, 0), 0);
    run_vec(mk("wr.c", 1, 0, 4'b0010, pk(0, 16'h0002, 0, 0), 4'b0010, 4'b0010, 16'h0004, 3'd3, 0), 0);
    run_vec(mk("wr.d", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b1000, 16'h0019, 3'd3, 0), 0);
    run_vec(mk("wr.e", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0001, 16'h0031, 3'd2, 0), 0);
    run_vec(mk("wr.f", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0010, 16'h0004, 3'd1, 0), 0);
    run_vec(mk("wr.g", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd0, 1), 0);

    // hold with two operations in flight: no grants, both results still return.
    run_vec(mk("hd.0", 1, 0, 4'b0001, pk(16'h0010, 0, 0, 0), 4'b0001, 4'b0000, 16'h0000, 3'd0, 0), 0);
    run_vec(mk("hd.1", 1, 0, 4'b0010, pk(0, 16'h0101, 0, 0), 4'b0010, 4'b0000, 16'h0000, 3'd1, 0), 0);
    run_vec(mk("hd.2", 1, 1, 4'b1111, pk(sd[0], sd[1], sd[2], sd[3]), 4'b0000, 4'b0000, 16'h0000, 3'd2, 0), 0);
    run_vec(mk("hd.3", 1, 1, 4'b1111, pk(sd[0], sd[1], sd[2], sd[3]), 4'b0000, 4'b0001, 16'h0100, 3'd2, 0), 0);
    run_vec(mk("hd.4", 1, 1, 4'b1111, pk(sd[0], sd[1], sd[2], sd[3]), 4'b0000, 4'b0010, 16'h0200, 3'd1, 0), 0);
    run_vec(mk("hd.5", 1, 1, 4'b1111, pk(sd[0], sd[1], sd[2], sd[3]), 4'b0000, 4'b0000, 16'h0000, 3'd0, 0), 0);
    run_vec(mk("hd.6", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd0, 1), 0);

    // Asynchronous reset while a response is on the bus and another is behind it.
    run_vec(mk("rm.0", 1, 0, 4'b0100, pk(0, 0, 16'h8000, 0), 4'b0100, 4'b0000, 16'h0000, 3'd0, 0), 0);
    run_vec(mk("rm.1", 1, 0, 4'b1000, pk(0, 0, 0, 16'h0003), 4'b1000, 4'b0000, 16'h0000, 3'd1, 0), 0);
    run_vec(mk("rm.2", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd2, 0), 0);
    applyStimulus(mk("rm.3", 1, 0, 4'b0000, 64'h0, 0, 0, 0, 0, 0), 0);
    #1;
    checkOutput("rm.3.rsp_valid", 64'(a_rsp_valid), 64'h4);
    checkOutput("rm.3.rsp_data",  64'(a_rsp_data),  64'h4000);
    checkOutput("rm.3.in_flight", 64'(a_in_flight), 64'd2);
    #1 reset = 1'b0;
    #1;
    checkOutput("rm.async.rsp_valid", 64'(a_rsp_valid), 64'h0);
    checkOutput("rm.async.rsp_data",  64'(a_rsp_data),  64'h0);
    checkOutput("rm.async.in_flight", 64'(a_in_flight), 64'd0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      run_vec(mk($sformatf("rm.post%0d", k), 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd0, 1), 0);
    end
    run_vec(mk("rm.first", 1, 0, 4'b1111, pk(sd[0], sd[1], sd[2], sd[3]), 4'b0001, 4'b0000, 16'h0000, 3'd0, 0), 0);
    run_vec(mk("rm.next", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd1, 0), 0);

    // EXTRA_STAGES=2 instance: same single transfer, five-edge latency.
    run_vec(mk("x2.c0", 1, 0, 4'b0001, pk(16'h0003, 0, 0, 0), 4'b0001, 4'b0000, 16'h0000, 3'd0, 0), 1);
    for (int k = 1; k <= 4; k++) begin
      run_vec(mk($sformatf("x2.c%0d", k), 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd1, 0), 1);
    end
    run_vec(mk("x2.c5", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0001, 16'h0009, 3'd1, 0), 1);
    run_vec(mk("x2.c6", 1, 0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 16'h0000, 3'd0, 1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
